// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/settle/capture sequencer around an 8-bit combinational ALU.
// Optional statistics counters are built only when ALU_ISSUE_STATS_EN is defined.
//
// state | meaning
// IDLE  | ready for a command; cmd_ready=1
// EXEC  | operands held on the ALU, settle timer counting down
// DONE  | response presented; waits for rsp_ready
module alu_issue_ctrl #(
  parameter int          EXEC_CYCLES = 1,
  parameter logic [2:0]  OP_ADD      = 3'b000,
  parameter logic [2:0]  OP_SUB      = 3'b001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic        cmd_use_acc,
  output logic [2:0]  alu_operation,
  output logic [7:0]  alu_operand_A,
  output logic [7:0]  alu_operand_B,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic [15:0] acc_out,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_carry
);

  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
    $error("alu_issue_ctrl: EXEC_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        cmd_fire, capture, rsp_fire;

  assign cmd_fire = (state == IDLE) && cmd_valid;
  assign capture  = (state == EXEC) && (cnt == 4'd0);
  assign rsp_fire = (state == DONE) && rsp_ready;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid)       state_nxt = EXEC;
      EXEC:    if (cnt == 4'd0)     state_nxt = DONE;
      DONE:    if (rsp_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == DONE);
  end

  // operand registers, settle timer and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_operation <= 3'd0;
      alu_operand_A <= 8'd0;
      alu_operand_B <= 8'd0;
      cnt           <= 4'd0;
      rsp_result    <= 16'd0;
      rsp_carry     <= 1'b0;
      rsp_zero      <= 1'b0;
      acc_out       <= 16'd0;
    end else if (cmd_fire) begin
      alu_operation <= cmd_op;
      alu_operand_B <= cmd_b;
      alu_operand_A <= cmd_use_acc ? acc_out[7:0] : cmd_a;
      cnt           <= CNT_INIT;
    end else if (capture) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      // the ALU holds a stale carry for ops that do not define one
      rsp_carry  <= ((alu_operation == OP_ADD) || (alu_operation == OP_SUB)) ? alu_carry : 1'b0;
      acc_out    <= alu_result;
    end else if (state == EXEC) begin
      cnt <= cnt - 4'd1;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  // saturating completion and carry-event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops   <= 16'd0;
      stat_carry <= 16'd0;
    end else if (rsp_fire) begin
      if (stat_ops != 16'hFFFF)                 stat_ops   <= stat_ops + 16'd1;
      if (rsp_carry && (stat_carry != 16'hFFFF)) stat_carry <= stat_carry + 16'd1;
    end
  end
`else
  // statistics disabled: constant outputs, no flops
  always_comb begin
    stat_ops   = 16'd0;
    stat_carry = 16'd0;
  end
  logic unused_rsp_fire;
  assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (EXEC_CYCLES=1 and 4) each driving a
// behavioural ALU; expected responses go through a scoreboard queue.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010;

  logic        rst_n[2];
  logic        cmd_valid[2], cmd_ready[2], cmd_use_acc[2];
  logic [2:0]  cmd_op[2], alu_op[2];
  logic [7:0]  cmd_a[2], cmd_b[2], alu_a[2], alu_b[2];
  logic [15:0] alu_result[2];
  logic        alu_carry[2], alu_zero[2];
  logic        rsp_valid[2], rsp_ready[2], rsp_carry[2], rsp_zero[2];
  logic [15:0] rsp_result[2], acc_out[2], stat_ops[2], stat_carry[2];

  // behavioural ALU: {carry, result}; non-arithmetic ops present a stale carry of 1
  function automatic logic [16:0] alu_f(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    logic [15:0] r;
    logic        c;
    case (op)
      ADD:     begin r = {8'h00, a} + {8'h00, b}; c = r[8];  end
      SUB:     begin r = {8'h00, a} - {8'h00, b}; c = (a < b); end
      MUL:     begin r = a * b;                   c = 1'b1;  end
      default: begin r = {8'h00, a & b};          c = 1'b1;  end
    endcase
    return {c, r};
  endfunction

  function automatic int exc(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign {alu_carry[g], alu_result[g]} = alu_f(alu_op[g], alu_a[g], alu_b[g]);
    assign alu_zero[g] = (alu_result[g] == 16'h0000);

    alu_issue_ctrl #(.EXEC_CYCLES((g == 0) ? 1 : 4)) u_dut (
      .clk(clk), .rst_n(rst_n[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_op(cmd_op[g]),
      .cmd_a(cmd_a[g]), .cmd_b(cmd_b[g]), .cmd_use_acc(cmd_use_acc[g]),
      .alu_operation(alu_op[g]), .alu_operand_A(alu_a[g]), .alu_operand_B(alu_b[g]),
      .alu_result(alu_result[g]), .alu_carry(alu_carry[g]), .alu_zero(alu_zero[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_result(rsp_result[g]),
      .rsp_carry(rsp_carry[g]), .rsp_zero(rsp_zero[g]), .acc_out(acc_out[g]),
      .stat_ops(stat_ops[g]), .stat_carry(stat_carry[g])
    );
  end

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        z;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_acc[2];
  int          exp_ops[2], exp_cy[2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge with the DUT idle; returns one negedge after the accept edge
  task automatic send(int d, logic [2:0] op, logic [7:0] a, logic [7:0] b, logic ua);
    logic [7:0]  ea;
    logic [16:0] r;
    exp_t        e;
    chk("cmd_ready_idle", 32'(cmd_ready[d]), 32'd1);
    ea = ua ? exp_acc[d][7:0] : a;
    r  = alu_f(op, ea, b);
    e.res = r[15:0];
    e.c   = (op == ADD || op == SUB) ? r[16] : 1'b0;
    e.z   = (r[15:0] == 16'h0000);
    sbq.push_back(e);
    exp_acc[d] = r[15:0];
    cmd_valid[d] = 1'b1; cmd_op[d] = op; cmd_a[d] = a; cmd_b[d] = b; cmd_use_acc[d] = ua;
    @(negedge clk);
    cmd_valid[d] = 1'b0; cmd_a[d] = 8'h5A; cmd_b[d] = 8'hA5; cmd_op[d] = 3'b111; cmd_use_acc[d] = 1'b0;
    chk("alu_operation", 32'(alu_op[d]), 32'(op));
    chk("alu_operand_A", 32'(alu_a[d]), 32'(ea));
    chk("alu_operand_B", 32'(alu_b[d]), 32'(b));
    chk("cmd_ready_busy", 32'(cmd_ready[d]), 32'd0);
  endtask

  task automatic recv(int d);
    int   n;
    exp_t e;
    n = 1;
    while (!rsp_valid[d] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(exc(d) + 1));
    chk("sb_depth", 32'(sbq.size()), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rsp_result", 32'(rsp_result[d]), 32'(e.res));
      chk("rsp_carry", 32'(rsp_carry[d]), 32'(e.c));
      chk("rsp_zero", 32'(rsp_zero[d]), 32'(e.z));
      chk("acc_out", 32'(acc_out[d]), 32'(e.res));
      if (rsp_ready[d]) begin
        exp_ops[d]++;
        if (e.c) exp_cy[d]++;
        @(negedge clk);
        chk("rsp_valid_drop", 32'(rsp_valid[d]), 32'd0);
        chk("cmd_ready_back", 32'(cmd_ready[d]), 32'd1);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; cmd_valid[d] = 1'b0; cmd_op[d] = 3'd0; cmd_a[d] = 8'd0;
      cmd_b[d] = 8'd0; cmd_use_acc[d] = 1'b0; rsp_ready[d] = 1'b1;
      exp_acc[d] = 16'd0; exp_ops[d] = 0; exp_cy[d] = 0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_cmd_ready", 32'(cmd_ready[d]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rsp", {15'd0, rsp_carry[d], rsp_result[d]}, 32'd0);
      chk("rst_acc", 32'(acc_out[d]), 32'd0);
      chk("rst_alu", {13'd0, alu_op[d], alu_a[d], alu_b[d]}, 32'd0);
      chk("rst_stats", {stat_ops[d], stat_carry[d]}, 32'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);

    // basic ADD / SUB / masked MUL / chaining on EXEC_CYCLES=1
    send(0, ADD, 8'hF0, 8'h20, 1'b0); recv(0);
    send(0, SUB, 8'h05, 8'h05, 1'b0); recv(0);
    send(0, SUB, 8'h05, 8'h06, 1'b0); recv(0);
    send(0, ADD, 8'hFF, 8'h01, 1'b0); recv(0);
    send(0, MUL, 8'hFF, 8'hFF, 1'b0); recv(0);
    send(0, ADD, 8'h03, 8'h04, 1'b0); recv(0);
    send(0, MUL, 8'h00, 8'h06, 1'b1); recv(0);
    chk("chain_acc", 32'(acc_out[0]), 32'h002A);

    // backpressure: response held for 5 cycles, pulsed command ignored
    rsp_ready[0] = 1'b0;
    send(0, ADD, 8'h12, 8'h34, 1'b0); recv(0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cmd_valid[0] = 1'b1; cmd_op[0] = SUB; cmd_a[0] = 8'h77; cmd_b[0] = 8'h11;
      end else begin
        cmd_valid[0] = 1'b0;
      end
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_rsp_result", 32'(rsp_result[0]), 32'h0046);
      chk("bp_cmd_ready", 32'(cmd_ready[0]), 32'd0);
      chk("bp_alu_a", 32'(alu_a[0]), 32'h12);
    end
    cmd_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    exp_ops[0]++;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp_release_ready", 32'(cmd_ready[0]), 32'd1);
    repeat (3) @(negedge clk);
    chk("bp_no_ghost", 32'(rsp_valid[0]), 32'd0);

    // EXEC_CYCLES=4: normal op, then reset mid-EXEC
    send(1, ADD, 8'h10, 8'h20, 1'b0); recv(1);
    send(1, MUL, 8'h03, 8'h04, 1'b0);
    @(negedge clk);
    #2 rst_n[1] = 1'b0;
    #1;
    chk("abort_cmd_ready", 32'(cmd_ready[1]), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("abort_rsp", {15'd0, rsp_carry[1], rsp_result[1]}, 32'd0);
    chk("abort_acc", 32'(acc_out[1]), 32'd0);
    chk("abort_alu", {13'd0, alu_op[1], alu_a[1], alu_b[1]}, 32'd0);
    chk("abort_stats", {stat_ops[1], stat_carry[1]}, 32'd0);
    void'(sbq.pop_back());
    exp_acc[1] = 16'd0; exp_ops[1] = 0; exp_cy[1] = 0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready[1]), 32'd1);
    chk("post_rst_valid", 32'(rsp_valid[1]), 32'd0);
    send(1, ADD, 8'h00, 8'h05, 1'b1); recv(1);
    send(1, ADD, 8'hF0, 8'h20, 1'b0); recv(1);
    send(1, MUL, 8'h02, 8'h03, 1'b0); recv(1);

`ifdef ALU_ISSUE_STATS_EN
    chk("stat_ops_e4", 32'(stat_ops[1]), 32'd3);
    chk("stat_carry_e4", 32'(stat_carry[1]), 32'd1);
    chk("stat_ops_e1", 32'(stat_ops[0]), 32'(exp_ops[0]));
    chk("stat_carry_e1", 32'(stat_carry[0]), 32'(exp_cy[0]));
`else
    chk("stat_ops_off", {stat_ops[0], stat_ops[1]}, 32'd0);
    chk("stat_carry_off", {stat_carry[0], stat_carry[1]}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
